mult_sweep_checker: RTL and testbench



---
 rtl/mult_sweep_pkg.sv | 19 +
 rtl/mult_sweep_ref.sv | 19 +
 rtl/mult_sweep_checker.sv | 147 ++++++++++++++
 tb/tb_mult_sweep_checker.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sweep_pkg.sv
// mult_sweep_pkg
// Shared types and helpers for the multiplier sweep checker.
//   state_t           : sweep controller state encoding
//   settle_cnt_width  : width of the settle counter for a given SETTLE
package mult_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // The counter must be able to hold SETTLE itself, so size it for SETTLE+1 codes.
  function automatic int settle_cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mult_sweep_ref.sv
// mult_sweep_ref
// Combinational golden product used by the sweep checker and by fabric-test benches.
// Ports:
//   a       in  WIDTH_A          operand a
//   b       in  WIDTH_B          operand b
//   product out WIDTH_A+WIDTH_B  zero-extended a*b at full width
module mult_sweep_ref #(
  parameter int WIDTH_A = 2,
  parameter int WIDTH_B = 2
) (
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic [WIDTH_A+WIDTH_B-1:0] product
);

  // Both operands are widened first so the multiply is evaluated at full product width.
  assign product = {{WIDTH_B{1'b0}}, a} * {{WIDTH_A{1'b0}}, b};

endmodule

// File: rtl/mult_sweep_checker.sv
// mult_sweep_checker
// Exhaustive operand sweep and product checker for the MultiplierLUT fabric test.
// Drives every (a,b) pair (b inner, a outer), waits SETTLE cycles, samples z and
// compares it with the golden product, counting mismatches.
// Ports:
//   clock0     in  1                  single clock
//   reset      in  1                  synchronous, active-high reset
//   start      in  1                  pulse that begins a sweep (ignored while busy)
//   a          out WIDTH_A            registered operand a to the multiplier
//   b          out WIDTH_B            registered operand b to the multiplier
//   z          in  WIDTH_A+WIDTH_B    product returned by the multiplier
//   busy       out 1                  sweep in progress
//   done       out 1                  sweep finished, held until next start/reset
//   pass       out 1                  valid with done, 1 iff err_count==0
//   err_count  out WIDTH_A+WIDTH_B+1  number of mismatching vectors
// Optional (macro MULT_SWEEP_FAIL_LOG_EN):
//   fail_valid out 1                  a mismatch has been logged
//   fail_a     out WIDTH_A            operand a of the first mismatch
//   fail_b     out WIDTH_B            operand b of the first mismatch
//   fail_z     out WIDTH_A+WIDTH_B    observed z of the first mismatch
module mult_sweep_checker
  import mult_sweep_pkg::*;
#(
  parameter int WIDTH_A = 2,
  parameter int WIDTH_B = 2,
  parameter int SETTLE  = 2
) (
  input  logic                       clock0,
  input  logic                       reset,
  input  logic                       start,
  output logic [WIDTH_A-1:0]         a,
  output logic [WIDTH_B-1:0]         b,
  input  logic [WIDTH_A+WIDTH_B-1:0] z,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [WIDTH_A+WIDTH_B:0]   err_count
`ifdef MULT_SWEEP_FAIL_LOG_EN
  ,
  output logic                       fail_valid,
  output logic [WIDTH_A-1:0]         fail_a,
  output logic [WIDTH_B-1:0]         fail_b,
  output logic [WIDTH_A+WIDTH_B-1:0] fail_z
`endif
);

  localparam int ZW = WIDTH_A + WIDTH_B;
  localparam int CW = settle_cnt_width(SETTLE);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [ZW-1:0] golden;
  logic          mismatch;
  logic          last_vec;
  logic [ZW:0]   err_next;

  mult_sweep_ref #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_ref (
    .a      (a),
    .b      (b),
    .product(golden)
  );

  assign mismatch = (z != golden);
  // The all-ones operand pair is the final vector of the sweep.
  assign last_vec = (&a) && (&b);
  assign err_next = err_count + {{ZW{1'b0}}, mismatch};

  // Sweep controller: start clears results and loads vector 0, SETTLE cycles pass
  // before each single-cycle CHECK, and CHECK either steps {a,b} as one counter
  // (b wraps into a) or finishes the sweep.
  always_ff @(posedge clock0) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      a          <= '0;
      b          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
`ifdef MULT_SWEEP_FAIL_LOG_EN
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_z     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            a          <= '0;
            b          <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef MULT_SWEEP_FAIL_LOG_EN
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_z     <= '0;
`endif
          end
        end

        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          err_count <= err_next;
`ifdef MULT_SWEEP_FAIL_LOG_EN
          // Only the first failing vector is kept.
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a;
            fail_b     <= b;
            fail_z     <= z;
          end
`endif
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            {a, b}     <= {a, b} + ZW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// tb_mult_sweep_checker
// Self-checking bench for mult_sweep_checker. A behavioural model predicts every
// output from the start edge and the elapsed cycle count; a registered multiplier
// (optionally with z bit 0 stuck at 0) closes the loop. A second instance with
// 3-bit operands and SETTLE=1 covers the wider configuration.
// Optional fail-log ports are connected when MULT_SWEEP_FAIL_LOG_EN is defined.
module tb_mult_sweep_checker;

  localparam int WA  = 2;
  localparam int WB  = 2;
  localparam int S   = 2;
  localparam int ZW  = WA + WB;
  localparam int V   = 1 << ZW;
  localparam int RUN = V * (S + 1);

  localparam int RUN3 = 64 * 2;

  logic clock0 = 1'b0;
  logic reset  = 1'b1;
  logic start  = 1'b0;
  logic start3 = 1'b0;
  logic fault_on = 1'b0;

  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [ZW-1:0] z;
  logic          busy, done, pass;
  logic [ZW:0]   err_count;

  logic [2:0] a3, b3;
  logic [5:0] z3;
  logic       busy3, done3, pass3;
  logic [6:0] err_count3;

`ifdef MULT_SWEEP_FAIL_LOG_EN
  logic          fail_valid;
  logic [WA-1:0] fail_a;
  logic [WB-1:0] fail_b;
  logic [ZW-1:0] fail_z;
  logic          fail_valid3;
  logic [2:0]    fail_a3, fail_b3;
  logic [5:0]    fail_z3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock0 = ~clock0;

  mult_sweep_checker #(.WIDTH_A(WA), .WIDTH_B(WB), .SETTLE(S)) dut (
    .clock0    (clock0),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef MULT_SWEEP_FAIL_LOG_EN
    ,
    .fail_valid(fail_valid),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_z    (fail_z)
`endif
  );

  mult_sweep_checker #(.WIDTH_A(3), .WIDTH_B(3), .SETTLE(1)) dut3 (
    .clock0    (clock0),
    .reset     (reset),
    .start     (start3),
    .a         (a3),
    .b         (b3),
    .z         (z3),
    .busy      (busy3),
    .done      (done3),
    .pass      (pass3),
    .err_count (err_count3)
`ifdef MULT_SWEEP_FAIL_LOG_EN
    ,
    .fail_valid(fail_valid3),
    .fail_a    (fail_a3),
    .fail_b    (fail_b3),
    .fail_z    (fail_z3)
`endif
  );

  // Multipliers under test: registered products, the main one optionally faulty.
  logic [ZW-1:0] z_reg;
  logic [5:0]    z3_reg;
  always @(posedge clock0) begin
    z_reg  <= fault_on ? ((ZW'(a) * ZW'(b)) & ZW'(14)) : (ZW'(a) * ZW'(b));
    z3_reg <= 6'(a3) * 6'(b3);
  end
  assign z  = z_reg;
  assign z3 = z3_reg;

  // Model bookkeeping: which edge accepted the current sweep and its fault mode.
  int edge_count = 0;
  bit reset_seen = 0;
  bit started    = 0;
  int start_edge = 0;
  bit run_fault  = 0;

  always @(posedge clock0) begin
    edge_count++;
    if (reset) begin
      reset_seen = 1;
      started    = 0;
    end else if (start && (!started || (edge_count - 1 - start_edge) >= RUN)) begin
      started    = 1;
      start_edge = edge_count;
      run_fault  = fault_on;
    end
  end

  function automatic bit vec_bad(input int j, input bit f);
    int p;
    p = (j / (1 << WB)) * (j % (1 << WB));
    return f && p[0];
  endfunction

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clock0) begin
    int d, k, e_err, first_bad;
    bit e_busy, e_done, e_pass;
    logic [WA-1:0] e_a;
    logic [WB-1:0] e_b;
    if (reset_seen) begin
      e_err = 0;
      first_bad = -1;
      if (!started) begin
        k = 0; e_busy = 0; e_done = 0;
      end else begin
        d = edge_count - start_edge;
        if (d < RUN) begin
          k = d / (S + 1); e_busy = 1; e_done = 0;
        end else begin
          k = V - 1; e_busy = 0; e_done = 1;
        end
        for (int j = 0; j < V; j++) begin
          if ((j + 1) * (S + 1) <= d && vec_bad(j, run_fault)) begin
            e_err++;
            if (first_bad < 0) first_bad = j;
          end
        end
      end
      e_a    = WA'(k / (1 << WB));
      e_b    = WB'(k % (1 << WB));
      e_pass = e_done && (e_err == 0);
      checks++;
      if (a !== e_a || b !== e_b || busy !== e_busy || done !== e_done ||
          pass !== e_pass || err_count !== (ZW+1)'(e_err)) begin
        failures++;
        $display("[TB] FAIL cycle_compare edge=%0d got a=%0d b=%0d busy=%0b done=%0b pass=%0b err=%0d want a=%0d b=%0d busy=%0b done=%0b pass=%0b err=%0d",
                 edge_count, a, b, busy, done, pass, err_count,
                 e_a, e_b, e_busy, e_done, e_pass, e_err);
      end
`ifdef MULT_SWEEP_FAIL_LOG_EN
      begin
        bit e_fv;
        logic [WA-1:0] e_fa;
        logic [WB-1:0] e_fb;
        logic [ZW-1:0] e_fz;
        e_fv = (first_bad >= 0);
        e_fa = e_fv ? WA'(first_bad / (1 << WB)) : '0;
        e_fb = e_fv ? WB'(first_bad % (1 << WB)) : '0;
        e_fz = e_fv ? ZW'((first_bad / (1 << WB)) * (first_bad % (1 << WB)) - 1) : '0;
        checks++;
        if (fail_valid !== e_fv || fail_a !== e_fa || fail_b !== e_fb || fail_z !== e_fz) begin
          failures++;
          $display("[TB] FAIL fail_log edge=%0d got v=%0b a=%0d b=%0d z=%0d want v=%0b a=%0d b=%0d z=%0d",
                   edge_count, fail_valid, fail_a, fail_b, fail_z, e_fv, e_fa, e_fb, e_fz);
        end
      end
`endif
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Pulse start, optionally sprinkle extra start pulses while busy, then pin the
  // done timing and final result of the main instance with literal values.
  task automatic apply_stimulus(input bit fault, input bit extra, input int exp_err);
    fault_on = fault;
    start = 1'b1;
    @(negedge clock0);
    start = 1'b0;
    check_output("start_a", a, 0);
    check_output("start_b", b, 0);
    check_output("start_busy", busy, 1);
    for (int c = 1; c < RUN; c++) begin
      start = (extra && $urandom_range(0, 3) == 0);
      @(negedge clock0);
    end
    start = 1'b0;
    check_output("done_early", done, 0);
    @(negedge clock0);
    check_output("done_on_time", done, 1);
    check_output("busy_end", busy, 0);
    check_output("final_err", err_count, exp_err);
    check_output("final_pass", pass, (exp_err == 0));
    check_output("final_a", a, 3);
    check_output("final_b", b, 3);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_a"}, a, 0);
    check_output({tag, "_b"}, b, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_pass"}, pass, 0);
    check_output({tag, "_err"}, err_count, 0);
`ifdef MULT_SWEEP_FAIL_LOG_EN
    check_output({tag, "_fail_valid"}, fail_valid, 0);
    check_output({tag, "_fail_z"}, fail_z, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clock0);
    reset = 1'b0;
    check_reset_values("reset");
    repeat ($urandom_range(1, 5)) @(negedge clock0);

    $display("[TB] ideal sweep");
    apply_stimulus(1'b0, 1'b0, 0);
    repeat ($urandom_range(1, 4)) @(negedge clock0);

    $display("[TB] stuck-at-0 z[0] sweep with extra start pulses");
    apply_stimulus(1'b1, 1'b1, 4);
`ifdef MULT_SWEEP_FAIL_LOG_EN
    check_output("log_valid", fail_valid, 1);
    check_output("log_a", fail_a, 1);
    check_output("log_b", fail_b, 1);
    check_output("log_z", fail_z, 0);
`endif
    @(negedge clock0);

    $display("[TB] clean rerun from done");
    apply_stimulus(1'b0, 1'b0, 0);
`ifdef MULT_SWEEP_FAIL_LOG_EN
    check_output("rerun_log_valid", fail_valid, 0);
`endif

    $display("[TB] reset at vector 7");
    start = 1'b1;
    @(negedge clock0);
    start = 1'b0;
    repeat (7 * (S + 1)) @(negedge clock0);
    check_output("vec7_a", a, 1);
    check_output("vec7_b", b, 3);
    reset = 1'b1;
    @(negedge clock0);
    reset = 1'b0;
    check_reset_values("midreset");
    repeat (2) @(negedge clock0);
    apply_stimulus(1'b1, 1'b0, 4);

    $display("[TB] random reset points and random fault runs");
    for (int r = 0; r < 3; r++) begin
      start = 1'b1;
      @(negedge clock0);
      start = 1'b0;
      repeat ($urandom_range(1, RUN - 1)) @(negedge clock0);
      reset = 1'b1;
      @(negedge clock0);
      reset = 1'b0;
      check_output("rand_reset_busy", busy, 0);
      check_output("rand_reset_done", done, 0);
      repeat ($urandom_range(1, 3)) @(negedge clock0);
      begin
        bit f;
        f = 1'($urandom_range(0, 1));
        apply_stimulus(f, 1'($urandom_range(0, 1)), f ? 4 : 0);
      end
    end

    $display("[TB] 3x3 operands, SETTLE=1");
    start3 = 1'b1;
    @(negedge clock0);
    start3 = 1'b0;
    check_output("w3_busy", busy3, 1);
    repeat (RUN3 - 1) @(negedge clock0);
    check_output("w3_done_early", done3, 0);
    @(negedge clock0);
    check_output("w3_done", done3, 1);
    check_output("w3_busy_end", busy3, 0);
    check_output("w3_pass", pass3, 1);
    check_output("w3_err", err_count3, 0);
    check_output("w3_last_a", a3, 7);
    check_output("w3_last_b", b3, 7);
    check_output("w3_last_z", z3, 49);

    repeat (2) @(negedge clock0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
